// File: rtl/ifmap_spad_ctrl.sv
// ifmap_spad_ctrl: master-side controller for the ifmap scratchpad.
// It loads DEPTH words from an upstream stream into the scratchpad.
// It then replays them PASSES times to the PE datapath through a 2-entry
// output FIFO, and pulses done after the last word is accepted.
// Optional macro IFMAP_SPAD_CTRL_ZERO_FLAG_EN adds out_zero. out_zero is a
// per-entry zero flag captured at push time, so PE zero-skip sees a register.
module ifmap_spad_ctrl #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 12,
  parameter int ADDR_W = 4,
  parameter int PASSES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [ADDR_W-1:0] spad_addr,
  output logic              spad_we,
  inout  wire  [WIDTH-1:0]  spad_data
`ifdef IFMAP_SPAD_CTRL_ZERO_FLAG_EN
  ,
  output logic              out_zero
`endif
);

  localparam int TOTAL = DEPTH * PASSES;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [3:0]        LAST_PASS = 4'(PASSES - 1);
  localparam logic [CNT_W-1:0]  LAST_OUT  = CNT_W'(TOTAL - 1);

  typedef enum logic [1:0] {IDLE, LOAD, READ} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [3:0]          pass_cnt;
  logic [CNT_W-1:0]    out_cnt;
  logic                reads_done;
  logic                in_flight;

  logic [WIDTH-1:0]    fifo_data [2];
  logic                fifo_head;
  logic [1:0]          fifo_cnt;
  logic                fifo_wr_idx;
  logic                pop;
  logic                push;
  logic                issue;
  logic [1:0]          outstanding;

`ifdef IFMAP_SPAD_CTRL_ZERO_FLAG_EN
  logic                fifo_zero [2];
`endif

  // Words held in the FIFO or still coming back from the scratchpad,
  // counted after this cycle's pop. Never exceeds 2, so the FIFO cannot overflow.
  assign pop         = (fifo_cnt != 2'd0) && out_ready;
  assign push        = in_flight;
  assign outstanding = fifo_cnt - {1'b0, pop} + {1'b0, in_flight};
  assign issue       = (state == READ) && !reads_done && (outstanding < 2'd2);
  assign fifo_wr_idx = fifo_head ^ fifo_cnt[0];

  assign busy      = (state != IDLE);
  assign in_ready  = (state == LOAD);
  assign spad_we   = (state == LOAD) && in_valid;
  assign out_valid = (fifo_cnt != 2'd0);
  assign out_data  = fifo_data[fifo_head];

  // The controller drives the bus only for writes, so a read never contends with the scratchpad.
  assign spad_data = spad_we ? in_data : 'z;

`ifdef IFMAP_SPAD_CTRL_ZERO_FLAG_EN
  assign out_zero = out_valid && fifo_zero[fifo_head];
`endif

  // Address mux: write pointer while loading, read pointer while reading.
  always_comb begin
    spad_addr = '0;
    case (state)
      LOAD:    spad_addr = wr_ptr;
      READ:    spad_addr = rd_ptr;
      default: spad_addr = '0;
    endcase
  end

  // Two-entry output FIFO; read data is captured one cycle after the issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_head <= 1'b0;
      fifo_cnt  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
`ifdef IFMAP_SPAD_CTRL_ZERO_FLAG_EN
        fifo_zero[i] <= 1'b0;
`endif
      end
    end else begin
      if (push) begin
        fifo_data[fifo_wr_idx] <= spad_data;
`ifdef IFMAP_SPAD_CTRL_ZERO_FLAG_EN
        fifo_zero[fifo_wr_idx] <= (spad_data == '0);
`endif
      end
      if (pop)
        fifo_head <= ~fifo_head;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // Sequencer: IDLE -> LOAD (DEPTH writes) -> READ (PASSES sweeps) -> IDLE with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pass_cnt   <= '0;
      out_cnt    <= '0;
      reads_done <= 1'b0;
      in_flight  <= 1'b0;
      done       <= 1'b0;
    end else begin
      done      <= 1'b0;
      in_flight <= issue;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= LOAD;
            wr_ptr <= '0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (wr_ptr == LAST_ADDR) begin
              state      <= READ;
              wr_ptr     <= '0;
              rd_ptr     <= '0;
              pass_cnt   <= '0;
              out_cnt    <= '0;
              reads_done <= 1'b0;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        READ: begin
          if (issue) begin
            if (rd_ptr == LAST_ADDR) begin
              rd_ptr   <= '0;
              pass_cnt <= pass_cnt + 1'b1;
              if (pass_cnt == LAST_PASS)
                reads_done <= 1'b1;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
          if (pop) begin
            out_cnt <= out_cnt + 1'b1;
            if (out_cnt == LAST_OUT) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ifmap_spad_ctrl.md
Name: ifmap_spad_ctrl

Overview:
- Master-side controller for the 12x16-bit ifmap scratchpad. It owns the scratchpad's addr, we and bidirectional data bus.
- On `start` it loads DEPTH words from an upstream valid/ready stream into the scratchpad.
- It then streams the stored words to the PE MAC datapath over a valid/ready output, PASSES times (ifmap reuse), and pulses `done`.
- Sits between the GLB/NoC ifmap delivery and the PE multiplier.

Parameters:
- WIDTH, 16, data word width
- DEPTH, 12, scratchpad words per load/pass (1..2^ADDR_W)
- ADDR_W, 4, scratchpad address width
- PASSES, 1, read passes over stored data per `start` (1..15)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset
- start  in  1  begin load+read sequence; sampled only in IDLE
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last output word is accepted
- in_valid  in  1  upstream word valid
- in_ready  out  1  controller accepts the upstream word
- in_data  in  WIDTH  upstream word
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts the output word
- out_data  out  WIDTH  output word
- spad_addr  out  ADDR_W  scratchpad address
- spad_we  out  1  scratchpad write enable (1 = write, 0 = read)
- spad_data  inout  WIDTH  scratchpad data bus

Interface rules:
- One clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- `spad_data` is driven with the write word only while `spad_we`=1; otherwise it is high-Z.

Behaviour:
- Reset (async, any state): state=IDLE; wr_ptr=0, rd_ptr=0, pass_cnt=0; output FIFO emptied, in-flight read cleared.
  - Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, done=0, spad_we=0, spad_addr=0.
- Scratchpad timing contract: a read is issued with spad_we=0 and addr A in cycle t. Data is valid on spad_data during cycle t+1 and is captured at the t+1 posedge. Writes commit at the posedge of the cycle with spad_we=1.
- IDLE: in_ready=0, spad_we=0.
  - start=1 -> LOAD; wr_ptr=0.
  - start in any other state is ignored.
- LOAD: in_ready=1.
  - spad_we, spad_addr and the spad_data drive are combinational: spad_we = in_valid, spad_addr = wr_ptr, spad_data = in_data.
  - Each handshake increments wr_ptr. At most one word per cycle, no bubbles required.
  - Handshake with wr_ptr==DEPTH-1 -> READ; rd_ptr=0, pass_cnt=0.
- READ: in_ready=0, spad_we=0, spad_addr=rd_ptr.
  - A read is issued in a cycle only when (FIFO occupancy + in-flight) < 2, counted after that cycle's output pop.
  - An issued read sets in-flight. The next cycle pushes spad_data into a 2-entry output FIFO.
  - rd_ptr wraps DEPTH-1 -> 0 and pass_cnt increments on wrap.
  - After the last issue of pass PASSES-1, no further reads are issued.
- Output port: out_valid = FIFO non-empty; out_data = FIFO head.
  - out_data and out_valid hold stable while out_valid=1 and out_ready=0.
  - Pop occurs on out_valid & out_ready. Push and pop in the same cycle are legal.
- Throughput: with out_ready held 1, the first out_valid occurs 2 cycles after READ entry; then 1 word/cycle.
- Completion: the pop of word DEPTH*PASSES -> done=1 for exactly that following cycle; state returns to IDLE in the same cycle. A start in the cycle where done=1 is accepted.
- busy=1 in LOAD and READ.
- spad_addr never exceeds DEPTH-1. The controller never drives spad_data while spad_we=0 (no bus contention).
- A reset mid-LOAD or mid-READ discards progress; scratchpad contents are undefined to later sequences.

Optional Feature:
- Macro IFMAP_SPAD_CTRL_ZERO_FLAG_EN.
- When defined: adds output port `out_zero` (1 bit), equal to (out_data==0) and qualified by out_valid (0 when out_valid=0). It is stored per FIFO entry at push time, not computed at the output, so PE zero-skip adds no combinational depth. Reset value 0.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Basic: start; feed in_data 1..12 back-to-back; out_ready=1; PASSES=1.
  -> spad_we high for exactly 12 cycles with addr 0..11.
  -> out_data 1..12 in order, 1 per cycle after 2-cycle latency.
  -> done pulses once; busy drops the same cycle.
- Backpressure: out_ready toggles 1,0,0,1 repeating.
  -> No word lost or duplicated; out_data stable while stalled.
  -> Never more than 2 reads outstanding; spad_addr held during stalls.
- Reuse: PASSES=3, data 0x100..0x10B.
  -> 36 outputs, sequence repeats 3 times; rd_ptr wraps 11->0; done only after output 36.
- Gappy input: in_valid random ~50%; start asserted mid-sequence.
  -> Writes occur only on handshake cycles; mid-sequence start ignored; correct 12-word output.
- Async reset: assert rst_n=0 mid-READ after 5 outputs.
  -> All outputs reach reset values immediately; spad_data high-Z (we=0).
  -> A new start reloads and streams correctly.
- ZERO_FLAG_EN: data with zeros at indices 0, 5, 11.
  -> out_zero=1 exactly on those outputs, 0 elsewhere and whenever out_valid=0.
